// File: rtl/pixel_req_pkg.sv
// ============================================================================
// pixel_req_pkg : shared types and data-word layout for the pixel requester
// Rev 1.0
// ============================================================================
`default_nettype none

package pixel_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int PKG_CNT_W    = 8;
  localparam int PKG_PIX_ID_W = 6;

  // Data word is {pixel id, ovf, count}, count in the low bits.
  localparam int CNT_LSB = 0;
  localparam int OVF_BIT = PKG_CNT_W;
  localparam int ID_LSB  = PKG_CNT_W + 1;
  localparam int DATA_W  = PKG_PIX_ID_W + PKG_CNT_W + 1;

  function automatic int f_ovf_bit(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int f_id_lsb(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int f_data_w(input int cnt_w, input int id_w);
    return id_w + cnt_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous level, reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pixel_req_client.sv
// ============================================================================
// pixel_req_client : pixel hit counter with snapshot and four-phase arbiter
// request / readout handshake. Option macro COUNT_SAT_EN: saturate counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_req_client
  import pixel_req_pkg::*;
#(
  parameter int CNT_W    = PKG_CNT_W,
  parameter int PIX_ID_W = PKG_PIX_ID_W,
  parameter int PIX_ID   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shutter_i,
  input  logic                      hit_i,
  output logic                      req_o,
  input  logic                      ack_i,
  output logic [PIX_ID_W+CNT_W:0]   data_o,
  output logic                      data_vld_o,
  input  logic                      rd_ack_i,
  output logic                      busy_o,
  output logic                      miss_o
);

  localparam int c_DATA_W  = f_data_w(CNT_W, PIX_ID_W);
  localparam int c_OVF_BIT = f_ovf_bit(CNT_W);
  localparam int c_ID_LSB  = f_id_lsb(CNT_W);
  localparam logic [PIX_ID_W-1:0] c_ID = PIX_ID_W'(PIX_ID);

  logic                w_ack_s;
  logic                r_shutter_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic [CNT_W-1:0]    r_shadow_cnt;
  logic                r_shadow_ovf;
  logic                r_miss;
  logic                r_pend;
  state_t              r_state;
  logic                r_req;
  logic                r_vld;
  logic                r_busy;
  logic [c_DATA_W-1:0] r_data;
  logic [c_DATA_W-1:0] w_word;
  logic                w_fall;
  logic                w_free;
  logic                w_take;
  logic                w_hit;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack_i),
    .o_q (w_ack_s)
  );

  assign w_fall = r_shutter_d & ~shutter_i;
  // A snapshot is only taken when no earlier word still owns the shadow.
  assign w_free = (r_state == IDLE) & ~r_pend;
  assign w_take = w_fall & w_free;
  assign w_hit  = shutter_i & hit_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_take) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (w_hit) begin
      if (&r_cnt) begin
        w_ovf_nxt = 1'b1;
`ifdef COUNT_SAT_EN
        w_cnt_nxt = r_cnt;
`else
        w_cnt_nxt = '0;
`endif
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shutter_d  <= 1'b0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_shadow_cnt <= '0;
      r_shadow_ovf <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_shutter_d <= shutter_i;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      if (w_take) begin
        r_shadow_cnt <= r_cnt;
        r_shadow_ovf <= r_ovf;
      end
      if (w_fall && !w_free) begin
        r_miss <= 1'b1;
      end
    end
  end

  always_comb begin
    w_word                         = '0;
    w_word[c_ID_LSB +: PIX_ID_W]   = c_ID;
    w_word[c_OVF_BIT]              = r_shadow_ovf;
    w_word[CNT_LSB +: CNT_W]       = r_shadow_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_req   <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Never re-request while the arbiter still shows a stale grant.
          if ((w_take || r_pend) && !w_ack_s) begin
            r_state <= REQ;
            r_pend  <= 1'b0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_take) begin
            r_pend <= 1'b1;
          end
        end
        REQ: begin
          if (w_ack_s) begin
            r_state <= SEND;
            r_vld   <= 1'b1;
            r_data  <= w_word;
          end
        end
        SEND: begin
          if (rd_ack_i) begin
            r_state <= RELEASE;
            r_req   <= 1'b0;
            r_vld   <= 1'b0;
            r_data  <= '0;
          end
        end
        RELEASE: begin
          if (!w_ack_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign req_o      = r_req;
  assign data_vld_o = r_vld;
  assign data_o     = r_data;
  assign busy_o     = r_busy;
  assign miss_o     = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_pixel_req_client.sv
// ============================================================================
// tb_pixel_req_client : table, random and corner-sequence bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pixel_req_client;

  localparam int TB_CNT_W = 8;
  localparam int TB_ID_W  = 6;
  localparam int TB_ID    = 37;
  localparam int TB_DW    = TB_ID_W + TB_CNT_W + 1;

`ifdef COUNT_SAT_EN
  localparam int EXP256 = 255;
  localparam int EXP300 = 255;
`else
  localparam int EXP256 = 0;
  localparam int EXP300 = 44;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              shutter = 1'b0;
  logic              hit = 1'b0;
  logic              ack = 1'b0;
  logic              rd_ack = 1'b0;
  logic              req;
  logic [TB_DW-1:0]  data;
  logic              vld;
  logic              busy;
  logic              miss;

  int n_vec = 0;
  int n_err = 0;

  pixel_req_client #(
    .CNT_W    (TB_CNT_W),
    .PIX_ID_W (TB_ID_W),
    .PIX_ID   (TB_ID)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .shutter_i  (shutter),
    .hit_i      (hit),
    .req_o      (req),
    .ack_i      (ack),
    .data_o     (data),
    .data_vld_o (vld),
    .rd_ack_i   (rd_ack),
    .busy_o     (busy),
    .miss_o     (miss)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word from the number of in-window hits.
  function automatic logic [TB_DW-1:0] exp_word(input int n);
    int   c;
    logic o;
    o = (n > 255);
`ifdef COUNT_SAT_EN
    c = (n > 255) ? 255 : n;
`else
    c = n % 256;
`endif
    return {TB_ID_W'(TB_ID), o, TB_CNT_W'(c)};
  endfunction

  task automatic window(input int n, input int noise, input bit gaps, input bit exp_req);
    for (int i = 0; i < noise; i++) begin
      hit = 1'b1; tick();
      hit = 1'b0; tick();
    end
    shutter = 1'b1; hit = 1'b0; tick();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        hit = 1'b0; tick();
      end
      hit = 1'b1; tick();
    end
    shutter = 1'b0; hit = 1'b1; tick();
    hit = 1'b0;
    chk("busy_after_fall", busy, exp_req);
    chk("req_after_fall", req, exp_req);
  endtask

  task automatic grant(input int dly, input logic [TB_DW-1:0] w);
    for (int i = 0; i < dly; i++) begin
      chk("req_wait_ack", req, 1);
      chk("vld_in_req", {vld, data}, 0);
      tick();
    end
    ack = 1'b1; tick();
    chk("vld_M+1", vld, 0);
    tick();
    chk("vld_M+2", vld, 0);
    tick();
    chk("vld_M+3", vld, 1);
    chk("req_send", req, 1);
    chk("data_send", data, w);
  endtask

  task automatic finish(input int rd_dly, input int hold, input logic [TB_DW-1:0] w);
    for (int i = 0; i < rd_dly; i++) begin
      tick();
      chk("vld_hold", vld, 1);
      chk("data_hold", data, w);
    end
    rd_ack = 1'b1; tick();
    rd_ack = 1'b0;
    chk("rel_outs", {req, vld, data}, 0);
    chk("rel_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      rd_ack = i[0];
      tick();
      chk("hold_busy", busy, 1);
      chk("hold_req", {req, vld}, 0);
    end
    rd_ack = 1'b0;
    ack = 1'b0; tick();
    chk("busy_L+1", busy, 1);
    tick();
    chk("busy_L+2", busy, 1);
    tick();
    chk("idle_L+3", {busy, req}, 0);
  endtask

  typedef struct {
    int nhits;
    int noise;
    int ack_dly;
    int rd_dly;
    int hold;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [TB_DW-1:0] w;
    int n;

    tbl[0] = '{5,   0, 3, 0, 0, 5,      1'b0};
    tbl[1] = '{0,   2, 0, 0, 0, 0,      1'b0};
    tbl[2] = '{255, 0, 1, 2, 0, 255,    1'b0};
    tbl[3] = '{256, 0, 0, 1, 3, EXP256, 1'b1};
    tbl[4] = '{300, 3, 2, 0, 6, EXP300, 1'b1};
    tbl[5] = '{1,   4, 5, 3, 0, 1,      1'b0};

    tick();
    chk("rst_req", req, 0);
    chk("rst_vld", vld, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss", miss, 0);
    rst = 1'b0;
    tick(); tick();

    foreach (tbl[i]) begin
      w = {TB_ID_W'(TB_ID), tbl[i].exp_ovf, TB_CNT_W'(tbl[i].exp_cnt)};
      window(tbl[i].nhits, tbl[i].noise, 1'b0, 1'b1);
      grant(tbl[i].ack_dly, w);
      finish(tbl[i].rd_dly, tbl[i].hold, w);
      tick();
    end

    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(0, 520);
      w = exp_word(n);
      window(n, $urandom_range(0, 3), 1'b1, 1'b1);
      grant($urandom_range(0, 4), w);
      finish($urandom_range(0, 3), $urandom_range(0, 4), w);
      tick();
    end

    // Second shutter fall during SEND: miss, counter keeps running.
    w = exp_word(5);
    window(5, 0, 1'b0, 1'b1);
    grant(2, w);
    shutter = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; tick();
    end
    hit = 1'b0; shutter = 1'b0; tick();
    chk("miss_set", miss, 1);
    chk("first_word_kept", {vld, data}, {1'b1, w});
    finish(1, 0, w);
    chk("miss_sticky", miss, 1);
    window(2, 0, 1'b0, 1'b1);
    grant(0, exp_word(5));
    finish(0, 0, exp_word(5));
    chk("miss_sticky2", miss, 1);

    // Reset while in SEND with the arbiter grant still high.
    window(7, 0, 1'b0, 1'b1);
    grant(1, exp_word(7));
    rst = 1'b1; #1;
    chk("async_rst_outs", {req, vld, data}, 0);
    chk("async_rst_flags", {busy, miss}, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    window(4, 0, 1'b0, 1'b0);
    tick();
    chk("no_rereq_1", req, 0);
    tick();
    chk("no_rereq_2", req, 0);
    ack = 1'b0; tick();
    chk("no_rereq_L+1", req, 0);
    tick();
    chk("no_rereq_L+2", req, 0);
    tick();
    chk("rereq_L+3", {req, busy}, 2'b11);
    grant(1, exp_word(4));
    finish(0, 0, exp_word(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
